// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit owning HI/LO; define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7..10).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_sel,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hin_q, hin_d, lon_q, lon_d;
  logic        is_mul, is_div, is_mac, sgn, commit;
  logic        neg_a, neg_b;
  logic [63:0] op_a, op_b, prod, res;
  logic [31:0] ua, ub, uq, ur, q, r;
`ifdef MDU_MADD_EN
  logic        acc_q, acc_d, sub_q, sub_d;
`endif
  always_comb begin
    is_mul = op == 4'd1 || op == 4'd2;
    is_div = op == 4'd3 || op == 4'd4;
`ifdef MDU_MADD_EN
    is_mac = op >= 4'd7 && op <= 4'd10;
`else
    is_mac = 1'b0;
`endif
    sgn = op == 4'd1 || op == 4'd3 || op == 4'd7 || op == 4'd9;
  end
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : (cnt_q == 4'd1 ? IDLE : RUN);
  always_comb begin
    busy   = state_q == RUN;
    commit = state_q == RUN && cnt_q == 4'd1;
    start  = op_valid && state_q == IDLE && (is_mul || is_div || is_mac);
  end
  assign rd_data = rd_sel ? hi_q : lo_q;
  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
  always_comb begin
    op_a  = sgn ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
    op_b  = sgn ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
    prod  = op_a * op_b;
    neg_a = sgn & rs_val[31];
    neg_b = sgn & rt_val[31];
    ua    = neg_a ? -rs_val : rs_val;
    ub    = neg_b ? -rt_val : rt_val;
    uq    = ua / ub;
    ur    = ua % ub;
    q     = (neg_a ^ neg_b) ? -uq : uq;
    r     = neg_a ? -ur : ur;
  end
`ifdef MDU_MADD_EN
  always_comb begin
    acc_d = start ? is_mac : acc_q;
    sub_d = start ? (op == 4'd9 || op == 4'd10) : sub_q;
    res   = !acc_q ? {hin_q, lon_q} :
            sub_q  ? {hi_q, lo_q} - {hin_q, lon_q} : {hi_q, lo_q} + {hin_q, lon_q};
  end
`else
  always_comb
    res = {hin_q, lon_q};
`endif
  // A zero divisor stages the current HI/LO, so the commit leaves them unchanged
  always_comb begin
    {hin_d, lon_d} = !start ? {hin_q, lon_q} :
                     !is_div ? prod :
                     rt_val == 32'b0 ? {hi_q, lo_q} : {r, q};
    cnt_d = start ? (is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES)) :
            state_q == RUN ? cnt_q - 4'd1 : cnt_q;
    hi_d  = commit ? res[63:32] : (op_valid && state_q == IDLE && op == 4'd5) ? rs_val : hi_q;
    lo_d  = commit ? res[31:0]  : (op_valid && state_q == IDLE && op == 4'd6) ? rs_val : lo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      hin_q <= '0;
      lon_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      hin_q <= hin_d;
      lon_q <= lon_d;
    end
  end
`ifdef MDU_MADD_EN
  always_ff @(posedge clk) begin
    acc_q <= reset ? 1'b0 : acc_d;
    sub_q <= reset ? 1'b0 : sub_d;
  end
`endif
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu with directed cases and randomized ops against a behavioural HI/LO model.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset, op_valid, start, busy;
  logic        rd_sel = 1'b0;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val, rd_data;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  typedef struct {logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t        exp_q[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] m = '0;
  logic        probe = 1'b0;
  logic        busy_prev = 1'b0;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .rd_sel(rd_sel), .start(start), .busy(busy), .rd_data(rd_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    longint sa, sbv, ps;
    longint unsigned uav, ubv, pu;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    uav = {32'b0, a};
    ubv = {32'b0, b};
    ps  = sa * sbv;
    pu  = uav * ubv;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: return (b == 0) ? cur : {32'(sa % sbv), 32'(sa / sbv)};
      4'd4: return (b == 0) ? cur : {a % b, a / b};
      4'd5: return {a, cur[31:0]};
      4'd6: return {cur[63:32], a};
      4'd7: return MADD ? cur + ps : cur;
      4'd8: return MADD ? cur + pu : cur;
      4'd9: return MADD ? cur - ps : cur;
      4'd10: return MADD ? cur - pu : cur;
      default: return cur;
    endcase
  endfunction

  // Monitor: a result is presented when busy falls, or when the stimulus flags a non-busy op
  always @(negedge clk) begin
    if ((busy_prev === 1'b1 && busy === 1'b0) || probe) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: got result with no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        rd_sel = 1'b0;
        #1 chk("lo", rd_data, e.lo);
        rd_sel = 1'b1;
        #1 chk("hi", rd_data, e.hi);
      end
    end
    busy_prev = busy;
  end

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input logic [31:0] eh, input logic [31:0] el, input bit intrude);
    logic [63:0] nm;
    bit          exp_start;
    int          n, exp_n;
    exp_start = (o >= 4'd1 && o <= 4'd4) || (MADD && o >= 4'd7 && o <= 4'd10);
    exp_n     = (o == 4'd3 || o == 4'd4) ? 10 : 5;
    nm        = lit ? {eh, el} : model(o, a, b, m);
    @(posedge clk);
    #1;
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    #1 chk("start", {31'b0, start}, {31'b0, exp_start});
    m = nm;
    exp_q.push_back('{nm[63:32], nm[31:0]});
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = 4'd0;
    if (exp_start) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        if (intrude && n == 3) begin
          op_valid = 1'b1; op = 4'd1; rs_val = $urandom; rt_val = $urandom;
          #1 chk("start_while_busy", {31'b0, start}, 32'd0);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = 4'd0;
      end
      chk("busy_cycles", n, exp_n);
    end else begin
      chk("busy_idle", {31'b0, busy}, 32'd0);
      probe = 1'b1;
      @(posedge clk);
      #1 probe = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    reset = 1'b1; op_valid = 1'b0; op = 4'd0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("busy_reset", {31'b0, busy}, 32'd0);
    exp_q.push_back('{32'd0, 32'd0});
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
    // Reset three cycles into a DIV aborts it and clears HI/LO
    do_op(4'd5, 32'h1111_2222, 32'd0, 0, 0, 0, 0);
    do_op(4'd6, 32'h3333_4444, 32'd0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    op_valid = 1'b1; op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mid_div", {31'b0, busy}, 32'd1);
    m = '0;
    exp_q.push_back('{32'd0, 32'd0});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("busy_after_reset", {31'b0, busy}, 32'd0);
    repeat (12) @(posedge clk);
    #1 chk("busy_no_resume", {31'b0, busy}, 32'd0);
    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
    do_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1, 32'h0000_0002, 32'hFFFF_FFFA, 0);
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op(4'd4, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 0);
    do_op(4'd5, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 32'h8000_0000, 0);
    do_op(4'd6, 32'h9ABC_DEF0, 32'd0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op(4'd5, 32'hAAAA_0000, 32'd0, 0, 0, 0, 0);
    do_op(4'd6, 32'h0000_5555, 32'd0, 0, 0, 0, 0);
    do_op(4'd3, 32'h1234_0000, 32'd0, 1, 32'hAAAA_0000, 32'h0000_5555, 1);
`ifdef MDU_MADD_EN
    do_op(4'd5, 32'd0, 32'd0, 0, 0, 0, 0);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0);
    do_op(4'd8, 32'd1, 32'd1, 1, 32'd1, 32'd0, 0);
    do_op(4'd9, 32'd1, 32'd1, 1, 32'd0, 32'hFFFF_FFFF, 0);
`else
    do_op(4'd7, 32'd5, 32'd6, 1, 32'hAAAA_0000, 32'h0000_5555, 0);
`endif
    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      do_op(o, a, b, 0, 0, 0, 0);
    end
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
